ddc_mixer_nch: RTL and testbench

DDC_MIXER_NCH -- requirements
Module: ddc_mixer_nch

---
 rtl/mixer_pkg.sv | 60 ++++++
 rtl/mixer_lane.sv | 133 +++++++++++++
 rtl/ddc_mixer_nch.sv | 78 +++++++
 tb/tb_ddc_mixer_nch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mixer_pkg
//  Description : Shared widths, pipeline latency and round/saturate helpers
//                for the multi-lane DDC I/Q mixer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mixer_pkg;

    localparam int DEF_LANES    = 4;
    localparam int DEF_SAMPLE_W = 12;
    localparam int DEF_LO_W     = 16;
    localparam int DEF_SHIFT    = 11;
    localparam int DEF_OUT_W    = 16;
    localparam int MIX_LATENCY  = 3;

    // Working width for rounding; wide enough for any legal product width.
    localparam int ACC_W = 64;

    // Add half an output LSB, then arithmetic shift (round half toward +inf).
    function automatic logic signed [ACC_W-1:0] round_shift(
        input logic signed [ACC_W-1:0] value,
        input int                      shift
    );
        logic signed [ACC_W-1:0] w_half;
        w_half = 64'sd1 <<< (shift - 1);
        return (value + w_half) >>> shift;
    endfunction

    // True when value lies outside the signed out_w-bit range.
    function automatic logic sat_hit(
        input logic signed [ACC_W-1:0] value,
        input int                      out_w
    );
        logic signed [ACC_W-1:0] w_max;
        logic signed [ACC_W-1:0] w_min;
        w_max = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        w_min = -(64'sd1 <<< (out_w - 1));
        return (value > w_max) || (value < w_min);
    endfunction

    // Clamp value into the signed out_w-bit range.
    function automatic logic signed [ACC_W-1:0] sat_clamp(
        input logic signed [ACC_W-1:0] value,
        input int                      out_w
    );
        logic signed [ACC_W-1:0] w_max;
        logic signed [ACC_W-1:0] w_min;
        w_max = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        w_min = -(64'sd1 <<< (out_w - 1));
        if (value > w_max) begin
            return w_max;
        end else if (value < w_min) begin
            return w_min;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mixer_lane.sv
`default_nettype none
// ============================================================================
//  Module      : mixer_lane
//  Description : One lane of the DDC mixer: S1 input register, S2 registered
//                multiply (with optional Q negation), S3 round + saturate.
//                Saturation is compiled in when MIXER_SAT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module mixer_lane
    import mixer_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int LO_W     = DEF_LO_W,
    parameter int SHIFT    = DEF_SHIFT,
    parameter int OUT_W    = DEF_OUT_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic signed [LO_W-1:0]     cos_i,
    input  logic signed [LO_W-1:0]     sin_i,
    input  logic                       invert_q_i,
    output logic signed [OUT_W-1:0]    inphase_o,
    output logic signed [OUT_W-1:0]    quadrature_o,
    output logic                       valid_o,
    output logic                       ovf_stb_o
);

    // One extra bit so that negating the most negative product cannot wrap.
    localparam int c_prod_w = SAMPLE_W + LO_W + 1;

    logic                       r_s1_valid;
    logic signed [SAMPLE_W-1:0] r_s1_sample;
    logic signed [LO_W-1:0]     r_s1_cos;
    logic signed [LO_W-1:0]     r_s1_sin;
    logic                       r_s1_inv;

    logic                       r_s2_valid;
    logic signed [c_prod_w-1:0] r_s2_prod_i;
    logic signed [c_prod_w-1:0] r_s2_prod_q;

    logic                       r_s3_valid;
    logic signed [OUT_W-1:0]    r_out_i;
    logic signed [OUT_W-1:0]    r_out_q;
    logic                       r_ovf_stb;

    logic signed [c_prod_w-1:0] w_sample_ext;
    logic signed [c_prod_w-1:0] w_cos_ext;
    logic signed [c_prod_w-1:0] w_sin_ext;
    logic signed [c_prod_w-1:0] w_mul_i;
    logic signed [c_prod_w-1:0] w_mul_q;
    logic signed [ACC_W-1:0]    w_round_i;
    logic signed [ACC_W-1:0]    w_round_q;
    logic signed [ACC_W-1:0]    w_res_i;
    logic signed [ACC_W-1:0]    w_res_q;
    logic                       w_hit;
    logic                       w_unused_hi;

    // S1: capture the sample, LO pair and inversion request together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= valid_i;
        end
        if (valid_i) begin
            r_s1_sample <= sample_i;
            r_s1_cos    <= cos_i;
            r_s1_sin    <= sin_i;
            r_s1_inv    <= invert_q_i;
        end
    end

    assign w_sample_ext = c_prod_w'(r_s1_sample);
    assign w_cos_ext    = c_prod_w'(r_s1_cos);
    assign w_sin_ext    = c_prod_w'(r_s1_sin);
    assign w_mul_i      = w_sample_ext * w_cos_ext;
    assign w_mul_q      = w_sample_ext * w_sin_ext;

    // S2: registered products, Q optionally negated for spectral inversion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
        end
        if (r_s1_valid) begin
            r_s2_prod_i <= w_mul_i;
            r_s2_prod_q <= r_s1_inv ? -w_mul_q : w_mul_q;
        end
    end

    assign w_round_i = round_shift(ACC_W'(r_s2_prod_i), SHIFT);
    assign w_round_q = round_shift(ACC_W'(r_s2_prod_q), SHIFT);

`ifdef MIXER_SAT_EN
    assign w_res_i = sat_clamp(w_round_i, OUT_W);
    assign w_res_q = sat_clamp(w_round_q, OUT_W);
    assign w_hit   = sat_hit(w_round_i, OUT_W) || sat_hit(w_round_q, OUT_W);
`else
    // Without saturation the output simply keeps the low bits (wraps).
    assign w_res_i = w_round_i;
    assign w_res_q = w_round_q;
    assign w_hit   = 1'b0;
`endif

    assign w_unused_hi = ^{w_res_i[ACC_W-1:OUT_W], w_res_q[ACC_W-1:OUT_W]};

    // S3: rounded/limited results plus a one-cycle clamp strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s3_valid <= 1'b0;
            r_ovf_stb  <= 1'b0;
            r_out_i    <= '0;
            r_out_q    <= '0;
        end else begin
            r_s3_valid <= r_s2_valid;
            r_ovf_stb  <= r_s2_valid & w_hit;
            if (r_s2_valid) begin
                r_out_i <= w_res_i[OUT_W-1:0];
                r_out_q <= w_res_q[OUT_W-1:0];
            end
        end
    end

    assign inphase_o    = r_out_i;
    assign quadrature_o = r_out_q;
    assign valid_o      = r_s3_valid;
    assign ovf_stb_o    = r_ovf_stb;

endmodule
`default_nettype wire

// File: rtl/ddc_mixer_nch.sv
`default_nettype none
// ============================================================================
//  Module      : ddc_mixer_nch
//  Description : N-lane parallel DDC complex mixer, fixed 3-cycle latency,
//                full throughput. Define MIXER_SAT_EN to enable output
//                saturation and the sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddc_mixer_nch
    import mixer_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int LO_W     = DEF_LO_W,
    parameter int SHIFT    = DEF_SHIFT,
    parameter int OUT_W    = DEF_OUT_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [LANES-1:0]          valid_i,
    input  logic [LANES*SAMPLE_W-1:0] sample_i,
    input  logic [LANES*LO_W-1:0]     cos_i,
    input  logic [LANES*LO_W-1:0]     sin_i,
    input  logic                      invert_q_i,
    input  logic                      ovf_clr_i,
    output logic [LANES*OUT_W-1:0]    inphase_o,
    output logic [LANES*OUT_W-1:0]    quadrature_o,
    output logic [LANES-1:0]          valid_o,
    output logic                      ovf_o
);

    logic [LANES-1:0] w_ovf_stb;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mixer_lane #(
            .SAMPLE_W (SAMPLE_W),
            .LO_W     (LO_W),
            .SHIFT    (SHIFT),
            .OUT_W    (OUT_W)
        ) u_lane (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .valid_i      (valid_i[k]),
            .sample_i     (sample_i[k*SAMPLE_W +: SAMPLE_W]),
            .cos_i        (cos_i[k*LO_W +: LO_W]),
            .sin_i        (sin_i[k*LO_W +: LO_W]),
            .invert_q_i   (invert_q_i),
            .inphase_o    (inphase_o[k*OUT_W +: OUT_W]),
            .quadrature_o (quadrature_o[k*OUT_W +: OUT_W]),
            .valid_o      (valid_o[k]),
            .ovf_stb_o    (w_ovf_stb[k])
        );
    end

`ifdef MIXER_SAT_EN
    logic r_ovf;

    // Sticky overflow: any lane strobe sets it, and a set beats a clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (|w_ovf_stb) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr_i) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf_o = r_ovf;
`else
    logic w_unused_ovf;

    assign w_unused_ovf = ovf_clr_i ^ (|w_ovf_stb);
    assign ovf_o        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddc_mixer_nch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddc_mixer_nch
//  Description : Directed self-checking bench for ddc_mixer_nch (defaults:
//                4 lanes, 12-bit samples, 16-bit LO, SHIFT 11, 16-bit out).
//                Expectations follow MIXER_SAT_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddc_mixer_nch;

`ifdef MIXER_SAT_EN
    localparam bit c_sat = 1'b1;
`else
    localparam bit c_sat = 1'b0;
`endif
    localparam int c_iters = 40;

    logic        clk;
    logic        rst_i;
    logic [3:0]  valid_i;
    logic [47:0] sample_i;
    logic [63:0] cos_i;
    logic [63:0] sin_i;
    logic        invert_q_i;
    logic        ovf_clr_i;
    logic [63:0] inphase_o;
    logic [63:0] quadrature_o;
    logic [3:0]  valid_o;
    logic        ovf_o;

    int n_checks = 0;
    int n_errors = 0;

    // Stream stimulus history and the model's view of the outputs.
    bit [3:0] h_v   [c_iters];
    int       h_s   [c_iters][4];
    int       h_c   [c_iters][4];
    int       h_n   [c_iters][4];
    bit       h_inv [c_iters];
    bit       h_rst [c_iters];
    bit [3:0] e_v;
    longint   e_i [4];
    longint   e_q [4];

    ddc_mixer_nch dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .sample_i     (sample_i),
        .cos_i        (cos_i),
        .sin_i        (sin_i),
        .invert_q_i   (invert_q_i),
        .ovf_clr_i    (ovf_clr_i),
        .inphase_o    (inphase_o),
        .quadrature_o (quadrature_o),
        .valid_o      (valid_o),
        .ovf_o        (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint obs_i(input int l);
        return longint'($signed(inphase_o[l*16 +: 16]));
    endfunction

    function automatic longint obs_q(input int l);
        return longint'($signed(quadrature_o[l*16 +: 16]));
    endfunction

    // Reference: full-precision product, round half up, then clamp or wrap.
    function automatic longint ref_mix(input int s, input int lo, input bit neg);
        longint p;
        longint r;
        p = longint'(s) * longint'(lo);
        if (neg) p = -p;
        r = (p + 1024) >>> 11;
        if (c_sat) begin
            if (r > 32767) r = 32767;
            else if (r < -32768) r = -32768;
            return r;
        end
        return longint'($signed(r[15:0]));
    endfunction

    task automatic drive_lane0(input int s, input int c, input int sn, input bit inv);
        valid_i         = 4'b0001;
        sample_i        = '0;
        cos_i           = '0;
        sin_i           = '0;
        sample_i[11:0]  = 12'(s);
        cos_i[15:0]     = 16'(c);
        sin_i[15:0]     = 16'(sn);
        invert_q_i      = inv;
    endtask

    initial begin
        rst_i      = 1'b1;
        valid_i    = 4'b1111;
        sample_i   = {4{12'd1000}};
        cos_i      = {4{16'd16384}};
        sin_i      = {4{16'd16384}};
        invert_q_i = 1'b0;
        ovf_clr_i  = 1'b0;

        // Reset held two cycles with all lanes presenting valid samples.
        tick();
        tick();
        check("reset_valid_o", longint'(valid_o), 0);
        check("reset_inphase", longint'(inphase_o), 0);
        check("reset_quadrature", longint'(quadrature_o), 0);
        check("reset_ovf", longint'(ovf_o), 0);
        rst_i   = 1'b0;
        valid_i = 4'b0000;

        // Basic lane-0 mix, 3-cycle latency, other lanes untouched.
        drive_lane0(1000, 16384, -16384, 1'b0);
        tick();
        valid_i = 4'b0000;
        tick();
        check("basic_early_valid", longint'(valid_o), 0);
        tick();
        check("basic_valid_o", longint'(valid_o), 1);
        check("basic_i0", obs_i(0), 8000);
        check("basic_q0", obs_q(0), -8000);
        check("basic_i_lanes123", longint'(inphase_o[63:16]), 0);
        check("basic_q_lanes123", longint'(quadrature_o[63:16]), 0);
        tick();
        check("basic_valid_drop", longint'(valid_o), 0);
        check("basic_i0_hold", obs_i(0), 8000);

        // Rounding boundaries, back to back.
        drive_lane0(3, 1023, 0, 1'b0);
        tick();
        drive_lane0(3, 1024, 0, 1'b0);
        tick();
        drive_lane0(-3, 1024, 0, 1'b0);
        tick();
        valid_i = 4'b0000;
        check("round_3x1023", obs_i(0), 1);
        tick();
        check("round_3x1024", obs_i(0), 2);
        tick();
        check("round_m3x1024", obs_i(0), -1);
        check("round_valid", longint'(valid_o), 1);
        tick();

        // Saturation and the sticky flag.
        drive_lane0(-2048, -32768, 0, 1'b0);
        tick();
        valid_i = 4'b0000;
        tick();
        tick();
        check("sat_i0", obs_i(0), c_sat ? 32767 : -32768);
        check("sat_ovf_not_yet", longint'(ovf_o), 0);
        tick();
        check("sat_ovf_set", longint'(ovf_o), longint'(c_sat));
        tick();
        check("sat_ovf_held", longint'(ovf_o), longint'(c_sat));
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        check("sat_ovf_cleared", longint'(ovf_o), 0);

        // Clear coinciding with a fresh overflow: the set must win.
        drive_lane0(-2048, -32768, 0, 1'b0);
        tick();
        valid_i = 4'b0000;
        tick();
        tick();
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        check("sat_set_beats_clr", longint'(ovf_o), longint'(c_sat));
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        check("sat_final_clr", longint'(ovf_o), 0);

        // Spectral inversion toggled every sample travels with each sample.
        for (int n = 0; n < 6; n++) begin
            if (n < 4) drive_lane0(1000, 0, 16384, n[0]);
            else valid_i = 4'b0000;
            tick();
            if (n >= 2) begin
                check("inv_q0", obs_q(0), (n % 2 == 1) ? -8000 : 8000);
                check("inv_valid", longint'(valid_o), 1);
            end
        end
        invert_q_i = 1'b0;

        // Random full-rate stream with resets at the start and mid-stream.
        for (int c = 0; c < c_iters; c++) begin
            h_rst[c] = (c == 0) || (c == 20);
            h_inv[c] = 1'($urandom_range(0, 1));
            h_v[c]   = (c % 7 == 3) ? 4'($urandom_range(0, 15)) : 4'b1111;
            rst_i      = h_rst[c];
            invert_q_i = h_inv[c];
            valid_i    = h_v[c];
            for (int l = 0; l < 4; l++) begin
                h_s[c][l] = $urandom_range(0, 4095) - 2048;
                h_c[c][l] = $urandom_range(0, 65535) - 32768;
                h_n[c][l] = $urandom_range(0, 65535) - 32768;
                sample_i[l*12 +: 12] = 12'(h_s[c][l]);
                cos_i[l*16 +: 16]    = 16'(h_c[c][l]);
                sin_i[l*16 +: 16]    = 16'(h_n[c][l]);
            end
            tick();
            if (h_rst[c]) begin
                e_v = 4'b0000;
                for (int l = 0; l < 4; l++) begin
                    e_i[l] = 0;
                    e_q[l] = 0;
                end
            end else if (c >= 2 && !h_rst[c-1] && !h_rst[c-2]) begin
                e_v = h_v[c-2];
                for (int l = 0; l < 4; l++) begin
                    if (h_v[c-2][l]) begin
                        e_i[l] = ref_mix(h_s[c-2][l], h_c[c-2][l], 1'b0);
                        e_q[l] = ref_mix(h_s[c-2][l], h_n[c-2][l], h_inv[c-2]);
                    end
                end
            end else begin
                e_v = 4'b0000;
            end
            check("stream_valid_o", longint'(valid_o), longint'(e_v));
            for (int l = 0; l < 4; l++) begin
                check("stream_i", obs_i(l), e_i[l]);
                check("stream_q", obs_q(l), e_q[l]);
            end
        end
        rst_i   = 1'b0;
        valid_i = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
